// File: rtl/oven_pkg.sv
// Shared constants for the oven controller: state encoding, temperature and
// bake-time limits, and a minutes-to-BCD helper.
package oven_pkg;

    localparam int TEMP_W = 10;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PREHEAT = 2'd1;
    localparam logic [1:0] S_BAKE    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [TEMP_W-1:0] TEMP_MIN     = 10'd150;
    localparam logic [TEMP_W-1:0] TEMP_MAX     = 10'd500;
    localparam logic [TEMP_W-1:0] TEMP_STEP    = 10'd5;
    localparam logic [TEMP_W-1:0] TEMP_DEFAULT = 10'd350;
    localparam logic [TEMP_W-1:0] AMBIENT      = 10'd70;
    localparam logic [TEMP_W-1:0] HEAT_RATE    = 10'd2;
    localparam logic [TEMP_W-1:0] COOL_RATE    = 10'd1;
    localparam logic [TEMP_W-1:0] HYST         = 10'd2;

    localparam logic [5:0] BAKE_DEFAULT = 6'd30;
    localparam logic [5:0] BAKE_MIN_LO  = 6'd1;
    localparam logic [5:0] BAKE_MIN_HI  = 6'd59;

    localparam logic [3:0] BUZZ_TICKS = 4'd10;

    // Binary minutes (0..59) to two BCD digits {tens, ones}.
    function automatic logic [7:0] min_to_bcd(input logic [5:0] m);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = m / 6'd10;
        ones = m - (tens * 6'd10);
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/oven_controller_bcd_mmss_down.sv
// mm:ss BCD down-counter for the bake timer; load sets min:00, dec steps
// one second with BCD borrow and stops at 00:00.
module bcd_mmss_down
    import oven_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic       dec,
    output logic [15:0] value,
    output logic       zero
);

    logic [15:0] value_r;
    logic [15:0] dec_val_s;
    logic        zero_s;

    assign zero_s = (value_r == 16'h0000);

    // One-second BCD decrement with borrow through s1, s10, m1, m10
    always_comb begin
        dec_val_s = value_r;
        if (value_r[3:0] != 4'd0) begin
            dec_val_s[3:0] = value_r[3:0] - 4'd1;
        end else begin
            dec_val_s[3:0] = 4'd9;
            if (value_r[7:4] != 4'd0) begin
                dec_val_s[7:4] = value_r[7:4] - 4'd1;
            end else begin
                dec_val_s[7:4] = 4'd5;
                if (value_r[11:8] != 4'd0) begin
                    dec_val_s[11:8] = value_r[11:8] - 4'd1;
                end else begin
                    dec_val_s[11:8]  = 4'd9;
                    dec_val_s[15:12] = value_r[15:12] - 4'd1;
                end
            end
        end
    end

    // Counter register: load wins over decrement; holds at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= {min_to_bcd(BAKE_DEFAULT), 8'h00};
        end else if (load) begin
            value_r <= {min_to_bcd(load_min), 8'h00};
        end else if (dec && !zero_s) begin
            value_r <= dec_val_s;
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
    assign zero  = zero_s;

endmodule

// File: rtl/oven_controller.sv
// Oven sequencing controller: entry, preheat, thermostatic timed bake, done.
// Optional buzzer on DONE is built only when OVEN_CTRL_BUZZER_EN is defined.
module oven_controller
    import oven_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                cancel,
    input  logic                temp_up,
    input  logic                temp_down,
    input  logic                time_up,
    input  logic                time_down,
    output logic [1:0]          state,
    output logic                heater_on,
    output logic [TEMP_W-1:0]   target_temp,
    output logic [TEMP_W-1:0]   cur_temp,
    output logic [15:0]         time_bcd,
    output logic                done,
    output logic                buzzer
);

    logic [1:0]        state_r, state_next_s;
    logic              heater_r, heater_next_s;
    logic [TEMP_W-1:0] target_r, target_next_s;
    logic [TEMP_W-1:0] cur_r, cur_next_s;
    logic [5:0]        bake_min_r, bake_min_next_s;
    logic              done_r;
    logic [TEMP_W:0]   heat_sum_s;
    logic [TEMP_W:0]   tgt_sum_s;
    logic [TEMP_W-1:0] thr_lo_s;
    logic [15:0]       time_bcd_s;
    logic              zero_s;
    logic              load_s;
    logic              dec_s;
    logic              last_s;

    assign thr_lo_s = target_r - HYST;
    assign last_s   = (time_bcd_s == 16'h0001) || zero_s;

    // Temperature model step on tick, driven by the registered heater command
    always_comb begin
        heat_sum_s = {1'b0, cur_r} + {1'b0, HEAT_RATE};
        if (tick) begin
            if (heater_r) begin
                cur_next_s = (heat_sum_s > {1'b0, TEMP_MAX}) ? TEMP_MAX : heat_sum_s[TEMP_W-1:0];
            end else begin
                cur_next_s = (cur_r < (AMBIENT + COOL_RATE)) ? AMBIENT : (cur_r - COOL_RATE);
            end
        end else begin
            cur_next_s = cur_r;
        end
    end

    // Target and bake-time entry, only honoured in IDLE; up beats down
    always_comb begin
        target_next_s   = target_r;
        bake_min_next_s = bake_min_r;
        tgt_sum_s       = {1'b0, target_r} + {1'b0, TEMP_STEP};
        if (state_r == S_IDLE) begin
            if (temp_up) begin
                target_next_s = (tgt_sum_s > {1'b0, TEMP_MAX}) ? TEMP_MAX : tgt_sum_s[TEMP_W-1:0];
            end else if (temp_down) begin
                target_next_s = (target_r < (TEMP_MIN + TEMP_STEP)) ? TEMP_MIN : (target_r - TEMP_STEP);
            end else begin
                target_next_s = target_r;
            end
            if (time_up) begin
                bake_min_next_s = (bake_min_r >= BAKE_MIN_HI) ? BAKE_MIN_HI : (bake_min_r + 6'd1);
            end else if (time_down) begin
                bake_min_next_s = (bake_min_r <= BAKE_MIN_LO) ? BAKE_MIN_LO : (bake_min_r - 6'd1);
            end else begin
                bake_min_next_s = bake_min_r;
            end
        end else begin
            target_next_s   = target_r;
            bake_min_next_s = bake_min_r;
        end
    end

    // Sequencer and thermostat; cancel overrides everything, including start
    always_comb begin
        state_next_s  = state_r;
        heater_next_s = heater_r;
        if (cancel) begin
            state_next_s  = S_IDLE;
            heater_next_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_next_s  = S_PREHEAT;
                        heater_next_s = 1'b1;
                    end else begin
                        state_next_s  = S_IDLE;
                        heater_next_s = 1'b0;
                    end
                end
                S_PREHEAT: begin
                    heater_next_s = 1'b1;
                    if (tick && (cur_next_s >= thr_lo_s)) begin
                        state_next_s = S_BAKE;
                    end else begin
                        state_next_s = S_PREHEAT;
                    end
                end
                S_BAKE: begin
                    if (tick) begin
                        if (last_s) begin
                            state_next_s  = S_DONE;
                            heater_next_s = 1'b0;
                        end else if (cur_next_s < thr_lo_s) begin
                            heater_next_s = 1'b1;
                        end else if (cur_next_s >= target_r) begin
                            heater_next_s = 1'b0;
                        end else begin
                            heater_next_s = heater_r;
                        end
                    end else begin
                        state_next_s  = S_BAKE;
                        heater_next_s = heater_r;
                    end
                end
                S_DONE: begin
                    heater_next_s = 1'b0;
                    if (start) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_DONE;
                    end
                end
                default: begin
                    state_next_s  = S_IDLE;
                    heater_next_s = 1'b0;
                end
            endcase
        end
    end

    // In IDLE (and on the way into or out of it) the counter mirrors bake_min:00
    assign load_s = (state_next_s == S_IDLE) || (state_r == S_IDLE);
    assign dec_s  = tick && (state_r == S_BAKE) && !load_s;

    bcd_mmss_down u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_min (bake_min_next_s),
        .dec      (dec_s),
        .value    (time_bcd_s),
        .zero     (zero_s)
    );

    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            heater_r   <= 1'b0;
            target_r   <= TEMP_DEFAULT;
            cur_r      <= AMBIENT;
            bake_min_r <= BAKE_DEFAULT;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            heater_r   <= heater_next_s;
            target_r   <= target_next_s;
            cur_r      <= cur_next_s;
            bake_min_r <= bake_min_next_s;
            done_r     <= (state_next_s == S_DONE);
        end
    end

`ifdef OVEN_CTRL_BUZZER_EN
    logic [3:0] buzz_cnt_r;
    logic       buzzer_r;

    // Buzzer toggles on each DONE tick for a fixed number of ticks, then rests
    always_ff @(posedge clk) begin
        if (rst) begin
            buzz_cnt_r <= 4'd0;
            buzzer_r   <= 1'b0;
        end else if ((state_next_s == S_DONE) && (state_r != S_DONE)) begin
            buzz_cnt_r <= BUZZ_TICKS;
            buzzer_r   <= 1'b0;
        end else if (state_next_s != S_DONE) begin
            buzz_cnt_r <= 4'd0;
            buzzer_r   <= 1'b0;
        end else if (tick && (buzz_cnt_r != 4'd0)) begin
            buzz_cnt_r <= buzz_cnt_r - 4'd1;
            buzzer_r   <= ~buzzer_r;
        end else begin
            buzz_cnt_r <= buzz_cnt_r;
            buzzer_r   <= buzzer_r;
        end
    end

    assign buzzer = buzzer_r;
`else
    assign buzzer = 1'b0;
`endif

    assign state       = state_r;
    assign heater_on   = heater_r;
    assign target_temp = target_r;
    assign cur_temp    = cur_r;
    assign time_bcd    = time_bcd_s;
    assign done        = done_r;

endmodule

// File: tb/tb_oven_controller.sv
// Self-checking bench for oven_controller: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_oven_controller;

    logic        clk = 1'b0;
    logic        rst, tick, start, cancel, temp_up, temp_down, time_up, time_down;
    logic [1:0]  state;
    logic        heater_on, done, buzzer;
    logic [9:0]  target_temp, cur_temp;
    logic [15:0] time_bcd;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model state: plain integers, countdown kept as total seconds
    int m_st, m_heat, m_tgt, m_cur, m_min, m_secs, m_bz, m_bcnt;

    oven_controller dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .cancel(cancel),
        .temp_up(temp_up), .temp_down(temp_down), .time_up(time_up), .time_down(time_down),
        .state(state), .heater_on(heater_on), .target_temp(target_temp), .cur_temp(cur_temp),
        .time_bcd(time_bcd), .done(done), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] secs_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model, advanced on every rising edge from the applied inputs
    always @(posedge clk) begin
        int nc, ns, nh, nt, nm, nsec, nb, nbc;
        if (rst) begin
            m_st <= 0; m_heat <= 0; m_tgt <= 350; m_cur <= 70; m_min <= 30;
            m_secs <= 30 * 60; m_bz <= 0; m_bcnt <= 0;
        end else begin
            nc = m_cur; ns = m_st; nh = m_heat; nt = m_tgt; nm = m_min; nsec = m_secs;
            nb = m_bz; nbc = m_bcnt;
            if (tick) nc = m_heat ? ((m_cur + 2 > 500) ? 500 : m_cur + 2)
                                  : ((m_cur - 1 < 70) ? 70 : m_cur - 1);
            if (m_st == 0) begin
                if (temp_up) nt = (nt + 5 > 500) ? 500 : nt + 5;
                else if (temp_down) nt = (nt - 5 < 150) ? 150 : nt - 5;
                if (time_up) nm = (nm + 1 > 59) ? 59 : nm + 1;
                else if (time_down) nm = (nm - 1 < 1) ? 1 : nm - 1;
                nh = 0;
                if (start) begin ns = 1; nh = 1; end
            end else if (m_st == 1) begin
                nh = 1;
                if (tick && nc >= m_tgt - 2) ns = 2;
            end else if (m_st == 2) begin
                if (tick) begin
                    nsec = nsec - 1;
                    if (nsec == 0) begin ns = 3; nh = 0; end
                    else if (nc < m_tgt - 2) nh = 1;
                    else if (nc >= m_tgt) nh = 0;
                end
            end else begin
                nh = 0;
                if (start) ns = 0;
            end
            if (cancel) begin ns = 0; nh = 0; end
            if (ns == 0 || m_st == 0) nsec = nm * 60;
            if (ns == 3 && m_st != 3) begin nb = 0; nbc = 10; end
            else if (ns != 3) begin nb = 0; nbc = 0; end
            else if (tick && m_bcnt > 0) begin nb = 1 - m_bz; nbc = m_bcnt - 1; end
            m_st <= ns; m_heat <= nh; m_tgt <= nt; m_cur <= nc; m_min <= nm;
            m_secs <= nsec; m_bz <= nb; m_bcnt <= nbc;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", state, m_st);
            check("heater", heater_on, m_heat);
            check("target", target_temp, m_tgt);
            check("cur_temp", cur_temp, m_cur);
            check("time_bcd", time_bcd, secs_bcd(m_secs));
            check("done", done, (m_st == 3) ? 1 : 0);
`ifdef OVEN_CTRL_BUZZER_EN
            check("buzzer", buzzer, m_bz);
`else
            check("buzzer", buzzer, 0);
`endif
        end
    end

    task automatic cyc(input bit tk, input bit st, input bit cn, input bit tu,
                       input bit td, input bit mu, input bit md);
        tick = tk; start = st; cancel = cn; temp_up = tu; temp_down = td;
        time_up = mu; time_down = md;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, lo, hi;
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_state", state, 0);
        check("rst_target", target_temp, 350);
        check("rst_cur", cur_temp, 70);
        check("rst_time", time_bcd, 16'h3000);
        check("rst_heater", heater_on, 0);
        check("rst_done", done, 0);

        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        check("target_max", target_temp, 500);
        for (int i = 0; i < 80; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        check("target_min", target_temp, 150);
        for (int i = 0; i < 60; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        check("time_min", time_bcd, 16'h0100);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        check("target_350", target_temp, 350);

        // Preheat from ambient with ticks only
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("preheat_state", state, 1);
        n = 0;
        while (state != 2'd2 && n < 400) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            n++;
            if (n == 10) cyc(0, 0, 0, 1, 0, 0, 0);
        end
        check("preheat_ticks", n, 139);
        check("bake_entry_cur", cur_temp, 348);
        check("preheat_target_locked", target_temp, 350);
        check("bake_entry_time", time_bcd, 16'h0100);

        // One-minute bake with thermostat
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("first_bake_tick", time_bcd, 16'h0059);
        n = 1; lo = cur_temp; hi = cur_temp;
        while (state != 2'd3 && n < 200) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            n++;
            if (cur_temp < lo) lo = cur_temp;
            if (cur_temp > hi) hi = cur_temp;
        end
        check("bake_ticks", n, 60);
        check("thermo_lo", lo, 347);
        check("thermo_hi", hi, 351);
        check("done_heater", heater_on, 0);
        check("done_flag", done, 1);
        check("done_time", time_bcd, 16'h0000);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("done_to_idle", state, 0);

        // cancel and start together mid-bake
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        n = 0;
        while (state != 2'd2 && n < 400) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            n++;
        end
        check("bake_reached", state, 2);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("cancel_state", state, 0);
        check("cancel_heater", heater_on, 0);
        check("cancel_target", target_temp, 350);
        check("cancel_time", time_bcd, 16'h0500);
        for (int i = 0; i < 400; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        check("cooled_floor", cur_temp, 70);

        // Randomized traffic, model checked every cycle
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 1499) == 0);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oven_controller.md
Name: oven_controller

Overview:
- Sequencing controller for the FPGA oven: target-temperature and bake-time entry, preheat, timed bake with bang-bang thermostat, done.
- Keeps the simulated oven temperature model and the mm:ss bake countdown.
- Sits between the button edge-detectors, the 1 Hz divider and the seven-segment/temperature display drivers.

Parameters:
- TEMP_MIN, 150, lowest selectable target (°F)
- TEMP_MAX, 500, highest selectable target; also ceiling of cur_temp
- TEMP_STEP, 5, target change per up/down pulse
- TEMP_DEFAULT, 350, target after reset
- AMBIENT, 70, cur_temp after reset; floor of cur_temp
- HEAT_RATE, 2, cur_temp rise per tick while heater on
- COOL_RATE, 1, cur_temp fall per tick while heater off
- HYST, 2, thermostat/preheat hysteresis
- BAKE_DEFAULT, 30, bake minutes after reset (legal 1..59)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 1 Hz enable from divider
- start  in  1  one-cycle pulse
- cancel  in  1  one-cycle pulse
- temp_up, temp_down  in  1 each  one-cycle pulses
- time_up, time_down  in  1 each  one-cycle pulses, ±1 minute
- state  out  2  0 IDLE, 1 PREHEAT, 2 BAKE, 3 DONE
- heater_on  out  1  heater command
- target_temp  out  10  binary target
- cur_temp  out  10  binary modelled temperature
- time_bcd  out  16  {m10,m1,s10,s1} BCD digits
- done  out  1  high in DONE
- buzzer  out  1  see Optional Feature

Behaviour:
- Reset: state IDLE, heater_on 0, target_temp TEMP_DEFAULT, cur_temp AMBIENT, bake_min BAKE_DEFAULT, time_bcd shows bake_min:00 (=16'h3000), done 0, buzzer 0.
- All outputs registered. Control responses take 1 cycle. Temperature and timer change only on tick cycles.
- Temperature model, applied on tick using the registered heater_on:
  - Heater on: cur_temp += HEAT_RATE, saturating at TEMP_MAX.
  - Heater off: cur_temp -= COOL_RATE, saturating at AMBIENT.
- IDLE:
  - heater_on 0.
  - temp_up/down: target ±TEMP_STEP, clamped to [TEMP_MIN, TEMP_MAX].
  - time_up/down: bake_min ±1, clamped to [1, 59].
  - time_bcd mirrors bake_min:00.
  - start: go to PREHEAT, load countdown = bake_min:00, heater_on 1.
- Target and time pulses are ignored in every state except IDLE.
- PREHEAT:
  - heater_on 1.
  - After the tick update, if cur_temp >= target - HYST, go to BAKE in the same cycle.
  - Countdown is frozen.
- BAKE, evaluated each tick:
  - Countdown decrements mm:ss with BCD borrow (s1 9→0 wraps, s10 5→0, minute borrow).
  - Thermostat: heater_on <= 1 if cur_temp (post-update) < target - HYST; 0 if >= target; otherwise unchanged.
  - The tick that reaches 00:00 goes to DONE with heater_on 0.
- DONE:
  - heater_on 0, done 1, time_bcd 00:00.
  - start or cancel: go to IDLE.
  - Cooling continues.
- cancel in any state: go to IDLE next cycle, heater_on 0, countdown discarded. target_temp and bake_min are retained.
- Simultaneous events:
  - cancel beats start.
  - In IDLE, up beats down when both arrive in one cycle.
  - An input pulse coincident with tick is processed in the same cycle, after that tick's updates.
- rst asserted mid-operation restores all reset values on the next edge, regardless of state.
- Arithmetic: 10-bit unsigned. Clamp before wrap; intermediate values need 11 bits.

Optional Feature:
- Macro OVEN_CTRL_BUZZER_EN.
- Defined: on entry to DONE, buzzer toggles every tick for 10 ticks, then holds 0. cancel, start or rst stops it immediately.
- Undefined: buzzer tied 0 and no buzzer counter is built.

Decomposition:
- Package oven_pkg holds:
  - state encoding constants S_IDLE=0, S_PREHEAT=1, S_BAKE=2, S_DONE=3
  - the temperature width (10)
  - the default temperature and time constants
- One sub-module, bcd_mmss_down:
  - inputs: load, load_min, dec (tick)
  - outputs: 16-bit BCD value, zero flag

Test Plan:
- Reset → state 0, target 350, cur_temp 70, time_bcd 16'h3000, heater 0, done 0.
- 40 temp_up pulses in IDLE → target 500. 80 temp_down pulses → 150. 60 time_down pulses → 01:00.
- target 350, start, ticks only:
  - BAKE entered on tick 139 (cur_temp 348).
  - heater 1 throughout preheat.
  - temp_up during PREHEAT → target stays 350.
- bake_min 1, reach BAKE:
  - time_bcd 16'h0100 → 16'h0059 on first tick.
  - DONE on tick 60, heater 0, done 1.
  - start → IDLE.
- Thermostat in BAKE at target 350: heater toggles off at cur_temp ≥350 and on again below 348. cur_temp stays within 347..351.
- cancel and start in the same cycle mid-BAKE → IDLE, heater 0, target and bake_min unchanged, cur_temp falls 1/tick to 70 and holds.
